lzrw1_decompressor: RTL and testbench

LZRW1_DECOMPRESSOR -- requirements
Module: lzrw1_decompressor

---
 rtl/lzrw1_decompressor_if.sv | 24 ++
 rtl/lzrw1_decompressor.sv | 155 +++++++++++++++
 tb/tb_lzrw1_decompressor.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lzrw1_decompressor_if.sv
// Byte-stream handshake bundle for the LZRW1 decompressor: compressed bytes in,
// decompressed bytes out, plus completion/error status.
interface lzrw1_decompressor_if;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_last;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_byte;
  logic        out_ready;
  logic        done;
  logic        err;
  logic [15:0] out_count;

  modport master (
    output in_valid, in_byte, in_last, out_ready,
    input  in_ready, out_valid, out_byte, done, err, out_count
  );

  modport slave (
    input  in_valid, in_byte, in_last, out_ready,
    output in_ready, out_valid, out_byte, done, err, out_count
  );
endinterface

// File: rtl/lzrw1_decompressor.sv
// LZRW1 stream decoder: control-word groups of 16 literal/copy items, one output
// byte per cycle, history window of HISTSIZE bytes; out_valid stalls hold output stable.
module lzrw1_decompressor #(
  parameter int HISTSIZE = 4096,
  parameter int MAXOUT   = 65535
) (
  input logic                  clock,
  input logic                  reset,
  lzrw1_decompressor_if.slave  bus
);
  localparam int              AW   = $clog2(HISTSIZE);
  localparam logic [AW:0]     PMAX = (AW+1)'(HISTSIZE);
  localparam logic [15:0]     OMAX = 16'(MAXOUT);

  typedef enum logic [2:0] {CTRL_LO, CTRL_HI, ITEM, COPY_B, COPY, DONE, ERR} state_t;

  state_t          state;
  logic [15:0]     ctrl;
  logic [3:0]      idx;
  logic [AW-1:0]   wptr;
  logic [AW:0]     produced;
  logic [4:0]      copy_left;
  logic [3:0]      off_hi;
  logic [11:0]     offset;
  logic            fin;
  logic            out_valid;
  logic [7:0]      out_byte;
  logic            done;
  logic            err;
  logic [15:0]     out_count;
  logic [7:0]      hist [HISTSIZE];

  logic            out_free, in_ready, accept, is_copy, off_bad;
  logic            lit_acc, copy_emit, hist_we, handoff;
  logic [11:0]     offset_b;
  logic [AW-1:0]   src;
  logic [7:0]      hist_wd;

  // fin blocks further input once the final item has been taken in
  assign out_free  = !out_valid || bus.out_ready;
  assign in_ready  = reset && !fin &&
                     (state == CTRL_LO || state == CTRL_HI || state == COPY_B ||
                      (state == ITEM && out_free));
  assign accept    = bus.in_valid && in_ready;
  assign is_copy   = ctrl[idx];
  assign offset_b  = {off_hi, bus.in_byte};
  assign off_bad   = (offset_b == 12'd0) || (int'(offset_b) > int'(produced));
  assign src       = wptr - AW'(offset);
  assign lit_acc   = accept && state == ITEM && !is_copy;
  assign copy_emit = state == COPY && out_free;
  assign hist_we   = reset && (lit_acc || copy_emit);
  assign hist_wd   = lit_acc ? bus.in_byte : hist[src];
  assign handoff   = out_valid && bus.out_ready;

  // Overlapping copies work because each emitted byte lands in history before the next read
  always_ff @(posedge clock) begin
    if (hist_we)
      hist[wptr] <= hist_wd;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= CTRL_LO;
      ctrl      <= '0;
      idx       <= '0;
      wptr      <= '0;
      produced  <= '0;
      copy_left <= '0;
      off_hi    <= '0;
      offset    <= '0;
      fin       <= 1'b0;
      out_valid <= 1'b0;
      out_byte  <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      out_count <= '0;
    end else begin
      if (handoff) begin
        out_valid <= 1'b0;
        if (out_count != OMAX)
          out_count <= out_count + 16'd1;
      end
      if (hist_we) begin
        out_valid <= 1'b1;
        out_byte  <= hist_wd;
        wptr      <= wptr + AW'(1);
        if (produced != PMAX)
          produced <= produced + (AW+1)'(1);
      end

      case (state)
        CTRL_LO: if (accept) begin
          ctrl[7:0] <= bus.in_byte;
          fin       <= bus.in_last;
          state     <= CTRL_HI;
        end
        CTRL_HI: if (accept) begin
          ctrl[15:8] <= bus.in_byte;
          fin        <= bus.in_last;
          idx        <= '0;
          state      <= ITEM;
        end
        ITEM: if (accept) begin
          if (is_copy) begin
            if (bus.in_last) begin
              err   <= 1'b1;
              state <= ERR;
            end else begin
              off_hi    <= bus.in_byte[3:0];
              copy_left <= {1'b0, bus.in_byte[7:4]} + 5'd3;
              state     <= COPY_B;
            end
          end else begin
            fin   <= bus.in_last;
            idx   <= idx + 4'd1;
            state <= (idx == 4'd15) ? CTRL_LO : ITEM;
          end
        end
        COPY_B: if (accept) begin
          if (off_bad) begin
            err   <= 1'b1;
            state <= ERR;
          end else begin
            offset <= offset_b;
            fin    <= bus.in_last;
            state  <= COPY;
          end
        end
        COPY: if (copy_emit) begin
          copy_left <= copy_left - 5'd1;
          if (copy_left == 5'd1) begin
            idx   <= idx + 4'd1;
            state <= (idx == 4'd15) ? CTRL_LO : ITEM;
          end
        end
        DONE, ERR: ;
        default: state <= ERR;
      endcase

      // Stream end: once the last output byte leaves, drop valid and latch done
      if (fin && out_free && (state == CTRL_LO || state == CTRL_HI || state == ITEM)) begin
        state     <= DONE;
        done      <= 1'b1;
        out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_byte  = out_byte;
  assign bus.done      = done;
  assign bus.err       = err;
  assign bus.out_count = out_count;
endmodule

// File: tb/tb_lzrw1_decompressor.sv
// Scoreboard bench for lzrw1_decompressor: directed streams plus random legal streams
// decoded by a queue-based reference decoder.
module tb_lzrw1_decompressor;
  typedef logic [7:0] bq_t [$];

  logic clock = 1'b0;
  logic reset = 1'b0;
  lzrw1_decompressor_if bus();

  lzrw1_decompressor #(.HISTSIZE(4096), .MAXOUT(65535)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int  tests  = 0;
  int  fails  = 0;
  int  or_mode = 0;
  int  hs_cnt = 0;
  bq_t sb;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bq_t mk(input string str);
    bq_t q;
    q = {};
    for (int i = 0; i < str.len(); i++) q.push_back(8'(str[i]));
    return q;
  endfunction

  // Reference decoder: walks the stream as groups, expands copies from the output so far
  function automatic void model(input bq_t s, output bq_t o, output bit e);
    int p, off, len;
    logic [15:0] c;
    o = {}; e = 1'b0; p = 0; c = '0;
    while (p < s.size()) begin
      c[7:0] = s[p]; p++;
      if (p >= s.size()) break;
      c[15:8] = s[p]; p++;
      for (int i = 0; i < 16 && p < s.size(); i++) begin
        if (!c[i]) begin
          o.push_back(s[p]); p++;
        end else begin
          if (p + 1 >= s.size()) begin e = 1'b1; return; end
          off = int'({s[p][3:0], s[p+1]});
          len = int'(s[p][7:4]) + 3;
          p += 2;
          if (off == 0 || off > o.size()) begin e = 1'b1; return; end
          for (int k = 0; k < len; k++) o.push_back(o[o.size() - off]);
        end
      end
    end
  endfunction

  function automatic bq_t gen();
    bq_t s, items;
    int groups, n, prod;
    logic [15:0] c;
    s = {}; prod = 0;
    groups = $urandom_range(1, 3);
    for (int g = 0; g < groups; g++) begin
      n = (g == groups - 1) ? $urandom_range(1, 16) : 16;
      c = '0; items = {};
      for (int i = 0; i < n; i++) begin
        if (prod > 0 && $urandom_range(0, 2) == 0) begin
          int off, lc;
          off = $urandom_range(1, (prod < 4095) ? prod : 4095);
          lc  = $urandom_range(0, 15);
          c[i] = 1'b1;
          items.push_back({lc[3:0], off[11:8]});
          items.push_back(off[7:0]);
          prod += lc + 3;
        end else begin
          items.push_back(8'($urandom_range(0, 255)));
          prod++;
        end
      end
      s.push_back(c[7:0]);
      s.push_back(c[15:8]);
      foreach (items[i]) s.push_back(items[i]);
    end
    return s;
  endfunction

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(negedge clock);
      case (or_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = !bus.out_ready;
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops one expected byte per handoff, and checks held output during stalls
  initial begin
    bit         stall;
    logic [7:0] held;
    stall = 1'b0; held = '0;
    forever begin
      @(negedge clock);
      #2;
      if (!reset) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          check("stall_valid", 32'(bus.out_valid), 32'd1);
          check("stall_byte", 32'(bus.out_byte), 32'(held));
        end
        if (bus.out_valid && bus.out_ready) begin
          hs_cnt++;
          if (sb.size() == 0) begin
            tests++; fails++;
            $display("FAIL out_unexpected: got byte %0h with no byte expected", bus.out_byte);
          end else begin
            check("out_byte", 32'(bus.out_byte), 32'(sb.pop_front()));
          end
        end
        stall = bus.out_valid && !bus.out_ready;
        held  = bus.out_byte;
      end
    end
  end

  task automatic do_reset();
    reset = 1'b0;
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_byte = '0;
    repeat (2) @(negedge clock);
    #2;
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_out_count", 32'(bus.out_count), 32'd0);
    #1 reset = 1'b1;
  endtask

  task automatic send(input bq_t s, input bit set_last, input int gap_max, output bit ok);
    ok = 1'b1;
    for (int i = 0; i < s.size() && ok; i++) begin
      int  w;
      bit  acc;
      repeat ($urandom_range(0, gap_max)) @(negedge clock);
      bus.in_valid = 1'b1;
      bus.in_byte  = s[i];
      bus.in_last  = set_last && (i == s.size() - 1);
      acc = 1'b0; w = 0;
      while (!acc && ok) begin
        #1 acc = bus.in_ready;
        @(negedge clock);
        if (++w > 400) begin
          tests++; fails++; ok = 1'b0;
          $display("FAIL send_timeout: byte %0d not accepted, in_ready=%0b required 1", i, bus.in_ready);
        end
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
    end
  endtask

  task automatic wait_end(input int budget, output bit hit);
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clock);
      #3;
      if (bus.done || bus.err) hit = 1'b1;
    end
    if (!hit) begin
      tests++; fails++;
      $display("FAIL end_timeout: done=%0b err=%0b, required one of them set", bus.done, bus.err);
    end
  endtask

  task automatic run(input string nm, input bq_t s, input bq_t exp, input bit exp_err,
                     input bit last, input int mode, input int gap, input bit rst);
    bit ok, hit;
    if (rst) do_reset();
    or_mode = mode;
    hs_cnt  = 0;
    foreach (exp[i]) sb.push_back(exp[i]);
    send(s, last, gap, ok);
    wait_end(8000, hit);
    if (hit) begin
      check({nm, "_err"}, 32'(bus.err), 32'(exp_err));
      check({nm, "_done"}, 32'(bus.done), 32'(!exp_err));
      check({nm, "_out_count"}, 32'(bus.out_count), 32'(exp.size()));
      check({nm, "_pending"}, 32'(sb.size()), 32'd0);
      check({nm, "_in_ready"}, 32'(bus.in_ready), 32'd0);
      if (!exp_err) check({nm, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    end
    sb.delete();
    or_mode = 0;
  endtask

  bq_t s029, s030, s031, s032, rs, ro, e029, e030, e031, none;
  bit  re, ok;

  initial begin
    bus.in_valid = 1'b0; bus.in_byte = '0; bus.in_last = 1'b0;
    none = {};
    s029 = {8'h00, 8'h00}; s029 = {s029, mk("TsIsSixteenChars")};
    e029 = mk("TsIsSixteenChars");
    s030 = {8'h08, 8'h00, 8'h61, 8'h62, 8'h63, 8'h30, 8'h03};
    e030 = mk("abcabcabc");
    s031 = {8'h02, 8'h00, 8'h61, 8'h20, 8'h01};
    e031 = mk("aaaaaa");
    s032 = {8'h01, 8'h00, 8'h00, 8'h05};

    do_reset();
    #1 check("ready_after_reset", 32'(bus.in_ready), 32'd1);
    @(negedge clock);

    run("literals", s029, e029, 1'b0, 1'b1, 0, 0, 1'b1);
    run("copy", s030, e030, 1'b0, 1'b1, 0, 0, 1'b1);
    run("overlap", s031, e031, 1'b0, 1'b1, 0, 1, 1'b1);
    run("illegal", s032, none, 1'b1, 1'b0, 0, 0, 1'b1);
    bus.in_valid = 1'b1; bus.in_byte = 8'h00;
    repeat (5) @(negedge clock);
    #3;
    check("illegal_sticky_err", 32'(bus.err), 32'd1);
    check("illegal_sticky_ready", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;
    @(negedge clock);
    run("backpressure", s030, e030, 1'b0, 1'b1, 1, 0, 1'b1);

    // Abort a copy after two copy bytes, then the next stream must decode from scratch
    do_reset();
    @(negedge clock);
    hs_cnt = 0;
    foreach (e030[i]) sb.push_back(e030[i]);
    send(s030, 1'b1, 0, ok);
    for (int i = 0; i < 200 && hs_cnt < 5; i++) begin
      @(negedge clock);
      #3;
    end
    check("midcopy_handoffs", 32'(hs_cnt), 32'd5);
    check("midcopy_left", 32'(sb.size()), 32'd4);
    sb.delete();
    do_reset();
    run("replay", s029, e029, 1'b0, 1'b1, 0, 0, 1'b0);

    for (int t = 0; t < 8; t++) begin
      rs = gen();
      model(rs, ro, re);
      run($sformatf("rand%0d", t), rs, ro, re, 1'b1, t % 3, $urandom_range(0, 2), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end
endmodule
